mic_delay_aligner: RTL
======================

Name: mic_delay_aligner

Overview:
- Upstream producer for the 16-channel sum-and-square power stage: buffers per-mic PCM samples and applies a per-mic steering delay in whole frames (delay-and-sum beamforming).
- Presents one time-aligned 16-sample frame per accepted input frame.
- Sits between the I2S mic receivers and the sum/square stage.
- Uses a valid/ready handshake on both sides, so it can be stalled by downstream power accumulation.

Parameters:
- MIC_NUMBER, 16, number of microphone channels.
- READBIT, 24, signed sample width.
- DEPTH, 32, frames stored per mic; must be a power of 2.
- DELAY_W, 5, delay field width; equals log2(DEPTH).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input frame valid.
- o_ready  out  1  input frame accepted when i_valid & o_ready.
- i_data  in  MIC_NUMBER x READBIT signed  current sample of each mic.
- i_delay  in  MIC_NUMBER x DELAY_W  per-mic steering delay, in frames.
- i_delay_we  in  1  one-cycle strobe that loads i_delay.
- o_valid  out  1  aligned frame valid.
- i_ready  in  1  downstream ready.
- o_data  out  MIC_NUMBER x READBIT signed  aligned frame.
- o_busy  out  1  high in WARMUP.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_valid=0, o_data all 0, o_busy=1.
  - wr_ptr=0, fill_cnt=0, state=WARMUP.
  - Delay registers all 0; max_delay=0.
  - Sample RAM contents are not reset.
- Ready logic: o_ready = ~o_valid | i_ready (combinational). A single output register with no skid buffer; full throughput when i_ready is held high.
- Accept (i_valid & o_ready):
  - Write i_data[m] to ram[m][wr_ptr].
  - wr_ptr <= wr_ptr+1, mod DEPTH (wraps 31->0).
  - fill_cnt saturates at DEPTH.
- Read address per mic: (wr_ptr - delay[m]) mod DEPTH, computed with the pre-increment wr_ptr.
  - delay 0 returns the sample being written this cycle (write-first bypass, no RAM read).
- Latency: o_data/o_valid are registered 1 cycle after the accept.
- Output hold: while o_valid & ~i_ready, o_data and o_valid stay stable. o_ready=0, so no accept and no pointer change.
- o_valid clears on (i_ready & no accept).
- States:
  - WARMUP: accepts are written but o_valid is not raised. Move to RUN when an accept makes fill_cnt > max_delay (i.e. when fill_cnt_next ≥ max_delay+1); that accept produces the first o_valid.
  - RUN: every accept produces an output frame.
- Delay load (i_delay_we):
  - Capture i_delay into the delay registers and recompute max_delay.
  - If the new max_delay ≥ fill_cnt, return to WARMUP (o_busy=1).
  - A frame accepted in the same cycle uses the OLD delays; new delays apply from the next accept.
  - Any delay value 0..DEPTH-1 is legal; no clamping is needed.
- Arithmetic: pointer math is unsigned DELAY_W bits with natural wrap; samples pass through untouched (no scaling, no sign change).
- Reset mid-operation: immediate return to reset state. The first DEPTH outputs after reset must never expose stale RAM, which the WARMUP gating guarantees.

Optional Feature:
- MIC_MASK_EN defined:
  - Adds input port i_mic_mask (MIC_NUMBER bits), registered on i_delay_we.
  - Masked mics output 0 in o_data.
  - Their delays are excluded from max_delay.
- Undefined: no port; all mics always pass.

Decomposition:
- Package beam_pkg:
  - Constants MIC_NUMBER, READBIT, DEPTH, DELAY_W.
  - Typedefs sample_t (signed READBIT), delay_t (DELAY_W), frame_t (array of sample_t).
  - enum align_state_t {WARMUP, RUN}.
- Sub-module mic_delay_line, one per mic via generate:
  - DEPTH x READBIT RAM with write port, read address input, and delay-0 bypass.
  - The top holds wr_ptr, fill_cnt, FSM, delay registers, and the output register.

Test Plan:
- Delays all 0; send frames with i_data[m]=100*k+m for k=0..3, i_ready=1 -> o_valid 1 cycle after each accept; o_data[m]=100*k+m; o_busy=0 after the first accept.
- Load delay[m]=m; stream k=0..40 -> no o_valid for accepts k=0..14; at accept k≥15, o_data[m]=100*(k-m)+m; check across the wr_ptr 31->0 wrap.
- All delays=31; stream 40 frames -> first o_valid at accept k=31, outputting o_data[m]=100*0+m; check a full-depth wrap.
- Hold i_ready=0 for 5 cycles after an output while i_valid=1 -> o_ready=0, o_data stable, wr_ptr unchanged; release -> the next frame follows with no loss or duplication.
- Reload delays with max 8 while fill_cnt=5 -> o_busy=1 and o_valid suppressed until fill_cnt=9; an accept in the same cycle as the load uses the old delays.
- Assert i_rst_n=0 mid-stream for 1 cycle -> o_valid=0 and o_data=0 asynchronously; restart in WARMUP with no stale frames output.

Source files
------------

// File: rtl/beam_pkg.sv
// -----------------------------------------------------------------------------
// beam_pkg
// Shared constants, types and helpers for the delay-and-sum front end.
//   MIC_NUMBER : number of microphone channels
//   READBIT    : signed PCM sample width
//   DEPTH      : frames stored per mic (power of 2)
//   DELAY_W    : delay field width, log2(DEPTH)
// -----------------------------------------------------------------------------
package beam_pkg;

    localparam int MIC_NUMBER = 16;
    localparam int READBIT    = 24;
    localparam int DEPTH      = 32;
    localparam int DELAY_W    = $clog2(DEPTH);

    typedef logic signed [READBIT-1:0] sample_t;
    typedef logic [DELAY_W-1:0]        delay_t;
    typedef sample_t [MIC_NUMBER-1:0]  frame_t;
    typedef delay_t  [MIC_NUMBER-1:0]  delay_vec_t;
    typedef logic [MIC_NUMBER-1:0]     mic_mask_t;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } align_state_t;

    // Largest delay among the mics whose enable bit is set.
    function automatic delay_t max_delay_of(input delay_vec_t d, input mic_mask_t en);
        delay_t mx;
        mx = '0;
        for (int m = 0; m < MIC_NUMBER; m++) begin
            if (en[m] && (d[m] > mx)) begin
                mx = d[m];
            end
        end
        return mx;
    endfunction

endpackage

// File: rtl/mic_delay_line.sv
// -----------------------------------------------------------------------------
// mic_delay_line
// One mic's circular sample store with a registered, enable-gated read.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we         : write wr_data at wr_addr
//   rd_en      : load the read register (one aligned output frame)
//   rd_addr    : frame to read back
//   bypass     : delay of zero -> return the sample being written this cycle
//   mute       : force the read register to zero (masked mic)
//   rd_data    : registered aligned sample
// The RAM array itself is never reset.
// -----------------------------------------------------------------------------
module mic_delay_line
    import beam_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    we,
    input  delay_t  wr_addr,
    input  sample_t wr_data,
    input  logic    rd_en,
    input  delay_t  rd_addr,
    input  logic    bypass,
    input  logic    mute,
    output sample_t rd_data
);

    sample_t ram [DEPTH];
    sample_t rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // A non-zero delay never addresses the slot being written, so the old
    // RAM contents are always the intended sample; delay 0 takes the bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            if (mute) begin
                rd_data_reg <= '0;
            end else if (bypass) begin
                rd_data_reg <= wr_data;
            end else begin
                rd_data_reg <= ram[rd_addr];
            end
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/mic_delay_aligner.sv
// -----------------------------------------------------------------------------
// mic_delay_aligner
// Buffers per-mic PCM frames and presents one time-aligned frame per accepted
// input frame, each mic delayed by its own whole-frame steering delay.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: input frame handshake (o_ready = ~o_valid | i_ready)
//   i_data         : current sample of every mic
//   i_delay        : per-mic delay in frames, loaded by the i_delay_we strobe
//   o_valid/i_ready: output frame handshake, output held while stalled
//   o_data         : aligned frame (registered, 1 cycle after the accept)
//   o_busy         : high while warming up (not enough history for max delay)
// Optional build macro MIC_MASK_EN adds i_mic_mask (loaded with i_delay_we):
// masked mics output zero and are excluded from the maximum delay.
// -----------------------------------------------------------------------------
module mic_delay_aligner
    import beam_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  frame_t     i_data,
    input  delay_vec_t i_delay,
    input  logic       i_delay_we,
`ifdef MIC_MASK_EN
    input  mic_mask_t  i_mic_mask,
`endif
    output logic       o_valid,
    input  logic       i_ready,
    output frame_t     o_data,
    output logic       o_busy
);

    delay_t             wr_ptr_reg;
    logic [DELAY_W:0]   fill_cnt_reg;
    logic [DELAY_W:0]   fill_cnt_next;
    align_state_t       state_reg;
    delay_vec_t         delay_reg;
    delay_t             max_delay_reg;
    delay_t             max_delay_next;
    logic               o_valid_reg;
    logic               accept;
    logic               out_en;
    mic_mask_t          mute_mask;

`ifdef MIC_MASK_EN
    mic_mask_t          mask_reg;

    assign mute_mask      = mask_reg;
    assign max_delay_next = max_delay_of(i_delay, ~i_mic_mask);
`else
    assign mute_mask      = '0;
    assign max_delay_next = max_delay_of(i_delay, '1);
`endif

    assign o_ready = ~o_valid_reg | i_ready;
    assign accept  = i_valid & o_ready;

    // History count saturates once every slot holds a written frame.
    assign fill_cnt_next = (accept && (fill_cnt_reg != (DELAY_W+1)'(DEPTH)))
                         ? fill_cnt_reg + 1'b1 : fill_cnt_reg;

    // In WARMUP the accept that brings the history past the largest delay is
    // the first one allowed to produce an output frame.
    assign out_en = accept & ((state_reg == RUN) | (fill_cnt_next > {1'b0, max_delay_reg}));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg    <= '0;
            fill_cnt_reg  <= '0;
            state_reg     <= WARMUP;
            delay_reg     <= '0;
            max_delay_reg <= '0;
            o_valid_reg   <= 1'b0;
`ifdef MIC_MASK_EN
            mask_reg      <= '0;
`endif
        end else begin
            fill_cnt_reg <= fill_cnt_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            o_valid_reg <= out_en | (o_valid_reg & ~i_ready);
            if ((state_reg == WARMUP) && out_en) begin
                state_reg <= RUN;
            end
            // A same-cycle accept already used the old delays above; the
            // new set only affects later accepts.
            if (i_delay_we) begin
                delay_reg     <= i_delay;
                max_delay_reg <= max_delay_next;
`ifdef MIC_MASK_EN
                mask_reg      <= i_mic_mask;
`endif
                if ({1'b0, max_delay_next} >= fill_cnt_reg) begin
                    state_reg <= WARMUP;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MIC_NUMBER; gi++) begin : g_mic
            delay_t rd_addr;

            // Pre-increment pointer minus delay, natural DELAY_W-bit wrap.
            assign rd_addr = wr_ptr_reg - delay_reg[gi];

            mic_delay_line u_line (
                .clk     (i_clk),
                .rst_n   (i_rst_n),
                .we      (accept),
                .wr_addr (wr_ptr_reg),
                .wr_data (i_data[gi]),
                .rd_en   (out_en),
                .rd_addr (rd_addr),
                .bypass  (delay_reg[gi] == '0),
                .mute    (mute_mask[gi]),
                .rd_data (o_data[gi])
            );
        end
    endgenerate

    assign o_valid = o_valid_reg;
    assign o_busy  = (state_reg == WARMUP);

endmodule
